// File: rtl/alu_muldiv_ctrl.sv
// Sequential 6x6 unsigned multiply / 6/6 unsigned divide controller built
// around a single shared 6-bit ripple-carry add/sub unit.

// 6-bit ripple-carry adder/subtractor: sel=0 -> x+y, sel=1 -> x-y.
// c_out is the raw carry XOR sel, so for subtraction 1 means borrow.
module ripple_carry_adder (
   input  logic [5:0] x,
   input  logic [5:0] y,
   input  logic       sel,
   output logic [5:0] sum,
   output logic       c_out,
   output logic       overflow
);
   logic [6:0] c;
   logic       yb;

   // Carry chain: one full adder per bit, y inverted and carry-in set for subtract
   always_comb begin
      c     = '0;
      sum   = '0;
      yb    = 1'b0;
      c[0]  = sel;
      for (int unsigned i = 0; i < 6; i++) begin
         yb       = y[i] ^ sel;
         sum[i]   = x[i] ^ yb ^ c[i];
         c[i+1]   = (x[i] & yb) | (x[i] & c[i]) | (yb & c[i]);
      end
      c_out    = c[6] ^ sel;
      overflow = c[6] ^ c[5];
   end
endmodule

module alu_muldiv_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       op,
   input  logic [5:0] a,
   input  logic [5:0] b,
   output logic       busy,
   output logic       done,
   output logic [5:0] result_hi,
   output logic [5:0] result_lo,
   output logic       div_by_zero
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t     state_q, state_d;
   logic       op_q;
   logic [5:0] m_q, acc_q, q_q;
   logic [2:0] cnt_q;
   logic       dbz_q;

   logic       accept, div_zero_req;
   logic [5:0] add_x, add_sum;
   logic       add_cout, unused_ovf;
   logic [5:0] acc_step, q_step;
   logic [5:0] mul_s;
   logic       mul_c;

   assign accept       = start && (state_q == IDLE || state_q == DONE);
   assign div_zero_req = op && (b == '0);

   // Divide shifts the partial remainder left before the trial subtract
   assign add_x = op_q ? {acc_q[4:0], q_q[5]} : acc_q;

   ripple_carry_adder u_adder (
      .x        (add_x),
      .y        (m_q),
      .sel      (op_q),
      .sum      (add_sum),
      .c_out    (add_cout),
      .overflow (unused_ovf)
   );

   // One multiply or divide step computed from the current registers
   always_comb begin
      acc_step = acc_q;
      q_step   = q_q;
      mul_c    = 1'b0;
      mul_s    = acc_q;
      if (!op_q) begin
         if (q_q[0]) begin
            mul_c = add_cout;
            mul_s = add_sum;
         end
         acc_step = {mul_c, mul_s[5:1]};
         q_step   = {mul_s[0], q_q[5:1]};
      end else begin
         // A shifted-out remainder MSB means the value exceeds any divisor
         if (acc_q[5] || !add_cout) begin
            acc_step = add_sum;
            q_step   = {q_q[4:0], 1'b1};
         end else begin
            acc_step = {acc_q[4:0], q_q[5]};
            q_step   = {q_q[4:0], 1'b0};
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state and handshake outputs
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = div_zero_req ? DONE : RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (cnt_q == 3'd5) state_d = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_d = div_zero_req ? DONE : RUN;
            else       state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand latch on accepted start, one step per RUN cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q  <= 1'b0;
         m_q   <= '0;
         acc_q <= '0;
         q_q   <= '0;
         cnt_q <= '0;
         dbz_q <= 1'b0;
      end else if (accept) begin
         op_q  <= op;
         m_q   <= b;
         cnt_q <= '0;
         dbz_q <= div_zero_req;
         if (div_zero_req) begin
            acc_q <= a;
            q_q   <= '1;
         end else begin
            acc_q <= '0;
            q_q   <= a;
         end
      end else if (state_q == RUN) begin
         acc_q <= acc_step;
         q_q   <= q_step;
         cnt_q <= cnt_q + 3'd1;
      end
   end

   assign result_hi   = acc_q;
   assign result_lo   = q_q;
   assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Directed self-checking bench for alu_muldiv_ctrl.
module tb_alu_muldiv_ctrl;
   logic       clk = 1'b0;
   logic       reset, start, op;
   logic [5:0] a, b;
   logic       busy, done, div_by_zero;
   logic [5:0] result_hi, result_lo;

   int n_checks = 0;
   int n_fail   = 0;

   alu_muldiv_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .result_hi   (result_hi),
      .result_lo   (result_lo),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one operation and check cycle-exact handshake and results.
   // disturb=1 toggles start and scrambles operands mid-RUN.
   task automatic run_op(input string tag, input logic o, input logic [5:0] av, input logic [5:0] bv,
                         input logic [5:0] exp_hi, input logic [5:0] exp_lo, input bit disturb);
      op = o; a = av; b = bv; start = 1'b1;
      tick();
      start = 1'b0;
      if (o && bv == 6'd0) begin
         check({tag, " dz_done"}, {11'd0, done}, 12'd1);
         check({tag, " dz_busy"}, {11'd0, busy}, 12'd0);
      end else begin
         for (int i = 0; i < 6; i++) begin
            check({tag, " busy"}, {10'd0, busy, done}, 12'b10);
            if (disturb && i == 2) begin
               start = 1'b1; a = ~av; b = ~bv; op = ~o;
            end
            if (disturb && i == 3) start = 1'b0;
            tick();
         end
         check({tag, " done"}, {10'd0, busy, done}, 12'b01);
      end
      check({tag, " result"}, {result_hi, result_lo}, {exp_hi, exp_lo});
      check({tag, " dbz"}, {11'd0, div_by_zero}, {11'd0, (o && bv == 6'd0)});
   endtask

   // One cycle with start low after done: done must drop, results hold
   task automatic idle_after(input string tag, input logic [5:0] exp_hi, input logic [5:0] exp_lo, input logic exp_dbz);
      start = 1'b0;
      tick();
      check({tag, " idle"}, {10'd0, busy, done}, 12'b00);
      check({tag, " hold"}, {result_hi, result_lo}, {exp_hi, exp_lo});
      check({tag, " hold_dbz"}, {11'd0, div_by_zero}, {11'd0, exp_dbz});
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
      tick(); tick();
      reset = 1'b0;
      check("reset outs", {7'd0, busy, done, div_by_zero, 2'd0}, 12'd0);
      check("reset res", {result_hi, result_lo}, 12'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("idle no done", {10'd0, busy, done}, 12'b00);
      end

      run_op("mul 6x7", 1'b0, 6'd6, 6'd7, 6'd0, 6'd42, 1'b0);
      idle_after("mul 6x7", 6'd0, 6'd42, 1'b0);
      run_op("mul 63x63", 1'b0, 6'd63, 6'd63, 6'd62, 6'd1, 1'b0);
      idle_after("mul 63x63", 6'd62, 6'd1, 1'b0);

      run_op("div 45/7", 1'b1, 6'd45, 6'd7, 6'd3, 6'd6, 1'b0);
      idle_after("div 45/7", 6'd3, 6'd6, 1'b0);
      run_op("div 63/1", 1'b1, 6'd63, 6'd1, 6'd0, 6'd63, 1'b0);
      idle_after("div 63/1", 6'd0, 6'd63, 1'b0);
      run_op("div 5/9", 1'b1, 6'd5, 6'd9, 6'd5, 6'd0, 1'b0);
      idle_after("div 5/9", 6'd5, 6'd0, 1'b0);

      run_op("div 20/0", 1'b1, 6'd20, 6'd0, 6'd20, 6'd63, 1'b0);
      idle_after("div 20/0", 6'd20, 6'd63, 1'b1);
      run_op("clr dbz 9x5", 1'b0, 6'd9, 6'd5, 6'd0, 6'd45, 1'b0);
      idle_after("clr dbz 9x5", 6'd0, 6'd45, 1'b0);

      run_op("disturb 50/6", 1'b1, 6'd50, 6'd6, 6'd2, 6'd8, 1'b1);
      // back-to-back: started while done is high
      run_op("b2b 13x11", 1'b0, 6'd13, 6'd11, 6'd2, 6'd15, 1'b0);
      run_op("b2b 33/4", 1'b1, 6'd33, 6'd4, 6'd1, 6'd8, 1'b0);
      idle_after("b2b 33/4", 6'd1, 6'd8, 1'b0);

      // reset in the 3rd RUN cycle
      op = 1'b0; a = 6'd31; b = 6'd31; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      check("pre-reset busy", {11'd0, busy}, 12'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid reset outs", {7'd0, busy, done, div_by_zero, 2'd0}, 12'd0);
      check("mid reset res", {result_hi, result_lo}, 12'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("aborted no done", {10'd0, busy, done}, 12'b00);
      end
      run_op("post-reset 31x31", 1'b0, 6'd31, 6'd31, 6'd15, 6'd1, 1'b0);
      idle_after("post-reset 31x31", 6'd15, 6'd1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time limit so the run always terminates
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach summary");
      $fatal(1);
   end
endmodule

// File: doc/alu_muldiv_ctrl.md
# alu_muldiv_ctrl

Sequential controller that reuses the Mini ALU's single 6-bit ripple-carry add/sub unit (`ripple_carry_adder`) to perform unsigned 6×6 multiply (shift-and-add) and unsigned 6÷6 divide (restoring shift-and-subtract). It owns the add/sub `sel` line, the operand registers and the step counter. It presents a start/busy/done handshake to the ALU top level. Exactly one `ripple_carry_adder` instance is used; no other arithmetic hardware is added.

## Interface
Parameters: none (width fixed at 6).

Clock and reset: one clock; reset is synchronous and active-high.

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  request; sampled only in IDLE or DONE
- op  input  1  0 = multiply, 1 = divide; latched with start
- a  input  6  multiplicand / dividend; latched with start
- b  input  6  multiplier / divisor; latched with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; results valid from this cycle
- result_hi  output  6  mul: product[11:6]; div: remainder
- result_lo  output  6  mul: product[5:0]; div: quotient
- div_by_zero  output  1  set with done when op=1 and b=0; cleared on next accepted start

## Operation
- State machine: IDLE, RUN, DONE. Internal registers:
  - M (6 bits): latched b.
  - ACC (6 bits).
  - Q (6 bits).
  - 3-bit step counter.
- Reset (any state): go to IDLE. ACC, Q, M and counter become 0. busy, done, div_by_zero, result_hi and result_lo are all 0.
- IDLE or DONE with start=1:
  - Latch op and M=b. Set Q=a, ACC=0, counter=0. Clear div_by_zero.
  - If op=1 and b=0: go to DONE with result_hi=a, result_lo=6'h3F, div_by_zero=1.
  - Otherwise go to RUN.
- DONE with start=0: go to IDLE. Results and div_by_zero hold until the next accepted start or reset.
- start in RUN is ignored. Changes on a, b or op during RUN are ignored.
- Multiply step (sel=0; adder inputs x=ACC, y=M):
  - If Q[0]=1: {C,S} = {c_out, sum}. Otherwise {C,S} = {0, ACC}.
  - Then {ACC,Q} ← {C,S,Q[5:1]}.
- Divide step (sel=1; adder inputs x={ACC[4:0],Q[5]}, y=M; r_msb=ACC[5]):
  - No borrow when r_msb=1 or c_out=0. Note that c_out = c5 XOR sel, so 0 means no borrow.
  - No borrow: ACC ← sum, Q ← {Q[4:0],1}.
  - Borrow: ACC ← {ACC[4:0],Q[5]}, Q ← {Q[4:0],0}.
- Each RUN cycle performs one step and increments the counter. After the step taken with counter=5, go to DONE.
- result_hi and result_lo mirror ACC and Q continuously; they are only architecturally valid when done=1 and afterwards.
- overflow from the adder is unused.

## Timing
- Start sampled at edge E0, non-zero path:
  - Steps execute at edges E1–E6.
  - busy=1 in the 6 cycles between E0 and E6.
  - done=1 in the single cycle between E6 and E7.
  - Latency from start to done is 7 cycles.
- Divide-by-zero: done=1 in the cycle between E0 and E1; busy stays 0.
- Back-to-back operation: start=1 while done=1 is accepted at that same edge. busy is high in the next cycle, with no idle cycle between operations.
- done never stays high for two consecutive cycles unless a new divide-by-zero start is accepted in DONE.
- Reset mid-RUN takes effect at the next edge: busy=0, done=0 and all results 0. No done pulse is produced for the aborted operation.

## Test plan
- Reset then idle: hold reset 2 cycles, release -> busy=0, done=0, result_hi=0, result_lo=0, div_by_zero=0; no done while start=0.
- Multiply: a=6, b=7, op=0 -> busy for 6 cycles, done on cycle 7 with result_hi=0, result_lo=42. Then a=63, b=63 -> result_hi=62, result_lo=1.
- Divide: a=45, b=7, op=1 -> done on cycle 7 with result_lo=6, result_hi=3. Then a=63, b=1 -> quotient 63, remainder 0. Then a=5, b=9 -> quotient 0, remainder 5.
- Divide by zero: a=20, b=0, op=1 -> done on cycle 1, busy never high, result_lo=63, result_hi=20, div_by_zero=1. A following valid start clears div_by_zero.
- Protocol:
  - Assert start and change a/b during RUN -> results unaffected.
  - Start asserted during the done cycle -> second operation is accepted with no gap and gives the correct result.
- Reset mid-operation: assert reset in the 3rd RUN cycle -> next cycle all outputs 0, no done. A new operation afterwards gives the correct result.
